// File: rtl/rgb_encoder_ctrl.sv
// Shared rotary-encoder / select-button controller for a three-channel RGB mixer.
// Decodes quadrature detents into saturating level steps on the currently selected channel.
module rgb_encoder_ctrl #(
  parameter int WIDTH           = 8,
  parameter int STEP            = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             btn,
  output logic [WIDTH-1:0] r_level,
  output logic [WIDTH-1:0] g_level,
  output logic [WIDTH-1:0] b_level,
  output logic [1:0]       sel,
  output logic             upd,
  output logic [1:0]       upd_ch,
  output logic             err
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MAX_EXT  = {1'b0, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {SEL_R = 2'd0, SEL_G = 2'd1, SEL_B = 2'd2} sel_t;

  logic              a_meta, a_sync, b_meta, b_sync, btn_meta, btn_sync;
  logic              armed;
  logic [1:0]        prev_ab;
  logic signed [2:0] acc, acc_next;
  logic              step_up, step_dn, up_next, dn_next, bad;
  logic [CNT_W-1:0]  dcnt, dcnt_next;
  logic              stable, stable_next, press;
  sel_t              state, state_next;
  logic [WIDTH-1:0]  cur_lvl, new_lvl;
  logic [WIDTH:0]    sum;

  // Two-flop synchronizers for the asynchronous pins
  always_ff @(posedge clk) begin
    if (rst) begin
      {a_meta, a_sync, b_meta, b_sync, btn_meta, btn_sync} <= 6'b000000;
    end else begin
      a_meta   <= A;    a_sync   <= a_meta;
      b_meta   <= B;    b_sync   <= b_meta;
      btn_meta <= btn;  btn_sync <= btn_meta;
    end
  end

  // Step is issued on the transition that would take the accumulator to +/-4
  always_comb begin
    acc_next = acc;
    up_next  = 1'b0;
    dn_next  = 1'b0;
    bad      = 1'b0;
    if (armed) begin
      case ({prev_ab, a_sync, b_sync})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
          if (acc == 3'sd3) begin
            acc_next = 3'sd0;
            up_next  = 1'b1;
          end else begin
            acc_next = acc + 3'sd1;
          end
        end
        4'b0100, 4'b1101, 4'b1011, 4'b0010: begin
          if (acc == -3'sd3) begin
            acc_next = 3'sd0;
            dn_next  = 1'b1;
          end else begin
            acc_next = acc - 3'sd1;
          end
        end
        4'b0011, 4'b1100, 4'b0110, 4'b1001: bad = 1'b1;
        default: acc_next = acc;
      endcase
    end else begin
      acc_next = 3'sd0;
    end
  end

  // Quadrature state, step decision and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      armed   <= 1'b0;
      prev_ab <= 2'b00;
      acc     <= 3'sd0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      err     <= 1'b0;
    end else begin
      armed   <= 1'b1;
      prev_ab <= {a_sync, b_sync};
      acc     <= acc_next;
      step_up <= up_next;
      step_dn <= dn_next;
      err     <= err | bad;
    end
  end

  // Debounce: count consecutive samples that disagree with the stable value
  always_comb begin
    dcnt_next   = 1'b0 ? dcnt : {CNT_W{1'b0}};
    stable_next = stable;
    if (btn_sync != stable) begin
      if (dcnt == DB_LAST) begin
        stable_next = btn_sync;
      end else begin
        dcnt_next = dcnt + CNT_W'(1);
      end
    end else begin
      dcnt_next = {CNT_W{1'b0}};
    end
    press = stable_next & ~stable;
  end

  // Debounce state
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt   <= {CNT_W{1'b0}};
      stable <= 1'b0;
    end else begin
      dcnt   <= dcnt_next;
      stable <= stable_next;
    end
  end

  // Select FSM next state
  always_comb begin
    state_next = state;
    case (state)
      SEL_R:   state_next = press ? SEL_G : SEL_R;
      SEL_G:   state_next = press ? SEL_B : SEL_G;
      SEL_B:   state_next = press ? SEL_R : SEL_B;
      default: state_next = SEL_R;
    endcase
  end

  // Select FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEL_R;
    end else begin
      state <= state_next;
    end
  end

  assign sel = state;

  // Saturating level arithmetic in WIDTH+1 bits; a borrow shows up in the top bit
  always_comb begin
    sum = {1'b0, cur_lvl};
    case (state)
      SEL_R:   cur_lvl = r_level;
      SEL_G:   cur_lvl = g_level;
      default: cur_lvl = b_level;
    endcase
    new_lvl = cur_lvl;
    if (step_up) begin
      sum     = {1'b0, cur_lvl} + STEP_EXT;
      new_lvl = (sum > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : sum[WIDTH-1:0];
    end else if (step_dn) begin
      sum     = {1'b0, cur_lvl} - STEP_EXT;
      new_lvl = sum[WIDTH] ? {WIDTH{1'b0}} : sum[WIDTH-1:0];
    end else begin
      new_lvl = cur_lvl;
    end
  end

  // Level registers and update strobe; step lands on the channel selected before any advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= {WIDTH{1'b0}};
      g_level <= {WIDTH{1'b0}};
      b_level <= {WIDTH{1'b0}};
      upd     <= 1'b0;
      upd_ch  <= 2'd0;
    end else begin
      upd <= 1'b0;
      if (new_lvl != cur_lvl) begin
        upd    <= 1'b1;
        upd_ch <= state;
        case (state)
          SEL_R:   r_level <= new_lvl;
          SEL_G:   g_level <= new_lvl;
          default: b_level <= new_lvl;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgb_encoder_ctrl.sv
// Directed self-checking bench for rgb_encoder_ctrl with hand-computed expectations.
module tb_rgb_encoder_ctrl;
  logic       clk = 1'b0;
  logic       rst, A, B, btn;
  logic [7:0] r_level, g_level, b_level;
  logic [1:0] sel, upd_ch, last_ch;
  logic       upd, err;
  int         tests = 0;
  int         fails = 0;
  int         upd_cnt = 0;
  int         base;

  rgb_encoder_ctrl #(.WIDTH(8), .STEP(1), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .btn(btn),
    .r_level(r_level), .g_level(g_level), .b_level(b_level),
    .sel(sel), .upd(upd), .upd_ch(upd_ch), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd) begin
      upd_cnt <= upd_cnt + 1;
      last_ch <= upd_ch;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ab(input logic [1:0] v, input int n);
    {A, B} = v;
    cyc(n);
  endtask

  task automatic cw();
    ab(2'b01, 4); ab(2'b11, 4); ab(2'b10, 4); ab(2'b00, 4);
  endtask

  task automatic ccw();
    ab(2'b10, 4); ab(2'b11, 4); ab(2'b01, 4); ab(2'b00, 4);
  endtask

  initial begin
    rst = 1'b1; A = 1'b0; B = 1'b0; btn = 1'b0;
    cyc(3);
    check("rst_r", r_level, 0); check("rst_sel", sel, 0);
    check("rst_upd", upd, 0);   check("rst_err", err, 0);
    check("rst_updch", upd_ch, 0);
    rst = 1'b0;
    cyc(2);

    cw(); cyc(4);
    check("cw1_r", r_level, 1); check("cw1_updcnt", upd_cnt, 1);
    check("cw1_ch", last_ch, 0); check("cw1_sel", sel, 0); check("cw1_err", err, 0);

    repeat (259) cw();
    cyc(4);
    check("sat_r", r_level, 255); check("sat_updcnt", upd_cnt, 255);
    ccw(); cyc(4);
    check("dn_r", r_level, 254); check("dn_updcnt", upd_cnt, 256);

    // Bouncy press, then a clean hold and release
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      cyc(1);
    end
    btn = 1'b1; cyc(40);
    check("press_sel", sel, 1);
    btn = 1'b0; cyc(30);
    check("release_sel", sel, 1);

    repeat (3) ccw();
    cyc(4);
    check("g_floor", g_level, 0); check("g_floor_updcnt", upd_cnt, 256);
    repeat (3) cw();
    cyc(4);
    check("g3", g_level, 3); check("g3_updcnt", upd_cnt, 259);
    check("g3_ch", last_ch, 1); check("g3_r", r_level, 254); check("g3_b", b_level, 0);

    // Half rotation and back: no step
    ab(2'b01, 4); ab(2'b11, 4); ab(2'b01, 4); ab(2'b00, 4); cyc(4);
    check("half_updcnt", upd_cnt, 259); check("half_g", g_level, 3);
    cw(); cyc(4);
    check("half_after_g", g_level, 4);

    // Illegal double-bit jumps
    ab(2'b11, 6);
    check("jump_err", err, 1); check("jump_g", g_level, 4);
    ab(2'b00, 6);
    cw(); cyc(4);
    check("jump_after_g", g_level, 5); check("jump_err_sticky", err, 1);
    check("jump_updcnt", upd_cnt, 261);

    btn = 1'b1; cyc(30); btn = 1'b0; cyc(30);
    check("sel_b", sel, 2);

    // Press completes on the same edge the final detent step lands
    btn = 1'b1; cyc(2);
    cw(); cyc(4);
    check("sim_b", b_level, 1); check("sim_ch", last_ch, 2);
    check("sim_sel", sel, 0); check("sim_r", r_level, 254);
    check("sim_g", g_level, 5); check("sim_updcnt", upd_cnt, 262);
    btn = 1'b0; cyc(30);
    check("sim_sel_hold", sel, 0);

    // Reset in the middle of a detent
    ab(2'b01, 4); ab(2'b11, 4);
    rst = 1'b1; cyc(1);
    A = 1'b0; B = 1'b0; cyc(2);
    check("mid_rst_r", r_level, 0); check("mid_rst_g", g_level, 0);
    check("mid_rst_b", b_level, 0); check("mid_rst_sel", sel, 0);
    check("mid_rst_err", err, 0);   check("mid_rst_upd", upd, 0);
    rst = 1'b0;
    base = upd_cnt;
    cyc(10);
    check("post_rst_updcnt", upd_cnt, base); check("post_rst_err", err, 0);
    check("post_rst_r", r_level, 0);
    cw(); cyc(4);
    check("post_rst_cw_r", r_level, 1); check("post_rst_cw_cnt", upd_cnt, base + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
